// File: rtl/mc_ctrl_if.sv
// Handshake and status bundle between the multicycle main controller and the
// rest of the RV32I core (IR, NPC unit, register file, instruction/data memories).
interface mc_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       opcode;
   logic             branch_taken;
   logic             imem_ack;
   logic             dmem_ack;
   logic             imem_req;
   logic             ir_write;
   logic             pc_write;
   logic [1:0]       npc_op;
   logic             dmem_req;
   logic             dmem_we;
   logic             rf_write;
   logic             illegal;
   logic [2:0]       state;
   logic [CNT_W-1:0] instret;

   // Controller side
   modport master (
      input  opcode, branch_taken, imem_ack, dmem_ack,
      output imem_req, ir_write, pc_write, npc_op, dmem_req, dmem_we,
             rf_write, illegal, state, instret
   );

   // Datapath / memory side
   modport slave (
      output opcode, branch_taken, imem_ack, dmem_ack,
      input  imem_req, ir_write, pc_write, npc_op, dmem_req, dmem_we,
             rf_write, illegal, state, instret
   );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle main control FSM for the RV32I core: sequences FETCH, DECODE,
// EXEC, MEM and WB, drives the PC write strobe and NPC select, handshakes with
// both memories, counts retired instructions and traps on illegal opcodes.
module mc_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   mc_ctrl_if.master   io_bus
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_REG    = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [1:0] NPC_PLUS4  = 2'b00;
   localparam logic [1:0] NPC_BRANCH = 2'b01;
   localparam logic [1:0] NPC_JUMP   = 2'b10;
   localparam logic [1:0] NPC_ALU    = 2'b11;

   state_t           r_state;
   logic [6:0]       r_opcode;
   logic             r_illegal;
   logic [CNT_W-1:0] r_instret;

   state_t           w_next;
   logic             w_retire;
   logic             w_trap;
   logic             w_imem_req;
   logic             w_ir_write;
   logic             w_pc_write;
   logic [1:0]       w_npc_op;
   logic             w_dmem_req;
   logic             w_dmem_we;
   logic             w_rf_write;

   function automatic logic f_legal(input logic [6:0] op);
      case (op)
         OP_REG, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH,
         OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: f_legal = 1'b1;
         default:                            f_legal = 1'b0;
      endcase
   endfunction

   // Next-state and strobe decode; strobes are combinational and forced off in reset
   always_comb begin
      w_next     = r_state;
      w_retire   = 1'b0;
      w_trap     = 1'b0;
      w_imem_req = 1'b0;
      w_ir_write = 1'b0;
      w_pc_write = 1'b0;
      w_npc_op   = NPC_PLUS4;
      w_dmem_req = 1'b0;
      w_dmem_we  = 1'b0;
      w_rf_write = 1'b0;
      case (r_state)
         S_FETCH: begin
            w_imem_req = 1'b1;
            if (io_bus.imem_ack) begin
               w_ir_write = 1'b1;
               w_pc_write = 1'b1;
               w_npc_op   = NPC_PLUS4;
               w_next     = S_DECODE;
            end
         end
         S_DECODE: begin
            if (f_legal(io_bus.opcode)) begin
               w_next = S_EXEC;
            end else begin
               w_next = S_TRAP;
               w_trap = 1'b1;
            end
         end
         S_EXEC: begin
            case (r_opcode)
               OP_BRANCH: begin
                  // PC already holds PC+4, so the NPC unit's BRANCH path subtracts 4
                  if (io_bus.branch_taken) begin
                     w_pc_write = 1'b1;
                     w_npc_op   = NPC_BRANCH;
                  end
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end
               OP_JAL: begin
                  w_pc_write = 1'b1;
                  w_npc_op   = NPC_JUMP;
                  w_next     = S_WB;
               end
               OP_JALR: begin
                  w_pc_write = 1'b1;
                  w_npc_op   = NPC_ALU;
                  w_next     = S_WB;
               end
               OP_LOAD, OP_STORE: w_next = S_MEM;
               default:           w_next = S_WB;
            endcase
         end
         S_MEM: begin
            w_dmem_req = 1'b1;
            w_dmem_we  = (r_opcode == OP_STORE);
            if (io_bus.dmem_ack) begin
               if (r_opcode == OP_STORE) begin
                  w_next   = S_FETCH;
                  w_retire = 1'b1;
               end else begin
                  w_next = S_WB;
               end
            end
         end
         S_WB: begin
            w_rf_write = 1'b1;
            w_next     = S_FETCH;
            w_retire   = 1'b1;
         end
         S_TRAP: w_next = S_TRAP;
         default: w_next = S_FETCH;
      endcase
      if (rst) begin
         w_imem_req = 1'b0;
         w_ir_write = 1'b0;
         w_pc_write = 1'b0;
         w_npc_op   = NPC_PLUS4;
         w_dmem_req = 1'b0;
         w_dmem_we  = 1'b0;
         w_rf_write = 1'b0;
      end
   end

   // State register, opcode latch, sticky trap flag and retire counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_FETCH;
         r_opcode  <= 7'd0;
         r_illegal <= 1'b0;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == S_DECODE) r_opcode <= io_bus.opcode;
         if (w_trap) r_illegal <= 1'b1;
         if (w_retire) r_instret <= r_instret + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign io_bus.imem_req = w_imem_req;
   assign io_bus.ir_write = w_ir_write;
   assign io_bus.pc_write = w_pc_write;
   assign io_bus.npc_op   = w_npc_op;
   assign io_bus.dmem_req = w_dmem_req;
   assign io_bus.dmem_we  = w_dmem_we;
   assign io_bus.rf_write = w_rf_write;
   assign io_bus.illegal  = r_illegal;
   assign io_bus.state    = r_state;
   assign io_bus.instret  = r_instret;

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
Multicycle main control FSM for the RV32I core. It sequences instruction fetch, decode, execute, memory and writeback. It drives the PC write strobe and the `NPCop` select of the next-PC unit, and handshakes with the instruction and data memories. It also counts retired instructions and traps on illegal opcodes.

Parameters:
- CNT_W, 32, width of the retired-instruction counter `instret`; wraps modulo 2^CNT_W.

Ports:
- clk  input  1  core clock, all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- opcode  input  7  instr[6:0] from IR; valid from DECODE onward
- branch_taken  input  1  ALU compare result for the current branch; valid in EXEC
- imem_ack  input  1  instruction memory ack; IR data valid in the same cycle
- dmem_ack  input  1  data memory ack; load data valid in the same cycle
- imem_req  output  1  instruction fetch request
- ir_write  output  1  latch instruction into IR
- pc_write  output  1  PC <= NPC at the next edge
- npc_op  output  2  NPC select: 00 PLUS4, 01 BRANCH, 10 JUMP, 11 ALU result
- dmem_req  output  1  data memory request
- dmem_we  output  1  store when 1, load when 0; valid with dmem_req
- rf_write  output  1  register file write enable
- illegal  output  1  sticky illegal-opcode flag
- state  output  3  current state, for debug
- instret  output  CNT_W  retired instruction count

Behaviour:
- Reset:
  - rst sampled high at an edge -> state=FETCH, instret=0, illegal=0, latched opcode=0.
  - While rst is high, all strobes (imem_req, ir_write, pc_write, dmem_req, dmem_we, rf_write) are forced 0 and npc_op=00.
  - Reset mid-instruction abandons it with no further writes.
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=7. Other codes return to FETCH.
- Outputs are combinational from state, latched opcode, branch_taken and the acks. They are not registered.
- FETCH:
  - imem_req=1.
  - On imem_ack: ir_write=1, pc_write=1, npc_op=00, next state DECODE. PC now holds fetched PC+4.
  - Without ack, stay in FETCH, holding imem_req high; there is no timeout.
- DECODE:
  - Latch opcode internally.
  - Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111 -> EXEC.
  - Any other opcode -> TRAP.
- EXEC:
  - Branch (1100011): if branch_taken, pc_write=1 and npc_op=01. NPC = PC+IMM-4, i.e. the branch target. Next state FETCH, instruction retires.
  - JAL (1101111): pc_write=1, npc_op=10, next WB.
  - JALR (1100111): pc_write=1, npc_op=11, next WB. The ALU result is already masked rs1+imm.
  - Load/store -> MEM.
  - All others (OP, OP-IMM, LUI, AUIPC) -> WB. AUIPC never uses npc_op=11.
- MEM:
  - dmem_req=1, with dmem_we=1 for store.
  - On dmem_ack: load -> WB; store -> FETCH and retires.
  - Without ack, hold the request.
- WB: rf_write=1 for exactly one cycle, next FETCH, retires.
- Retire: instret increments by 1 on the edge leaving the retiring state. Exactly one increment per instruction; wraps from all-ones to 0.
- TRAP:
  - illegal=1; all strobes 0.
  - Stays in TRAP until rst.
  - The trapping instruction does not retire.
- Acks that arrive while the corresponding req is low are ignored.
- pc_write never asserts outside FETCH (with ack) or EXEC.
- Latency with zero-wait memories:
  - OP / OP-IMM / LUI / AUIPC / JAL / JALR: 4 cycles.
  - Branch: 3 cycles.
  - Store: 4 cycles.
  - Load: 5 cycles.
  - Each memory wait cycle adds 1.

Test Plan:
- Reset, imem_ack tied 1, opcode=0110011 -> states 0,1,2,4,0. ir_write/pc_write(npc_op=00) in cycle 0, rf_write in cycle 3, instret=1 after 4 cycles.
- Branch 1100011 with branch_taken=1 -> pc_write=1, npc_op=01 in EXEC, no rf_write, instret+1 after 3 cycles. With branch_taken=0 -> pc_write=0 in EXEC.
- Load 0000011 with dmem_ack delayed 2 cycles -> dmem_req high for 3 cycles with dmem_we=0, then WB rf_write, total 7 cycles. Store 0100011 -> dmem_we=1, no WB.
- JALR 1100111 -> EXEC pc_write=1 with npc_op=11, then WB rf_write=1. JAL -> npc_op=10 in EXEC.
- opcode=1111111 -> TRAP (state=7), illegal=1 sticky, all strobes 0 for 20 cycles, instret unchanged. rst clears illegal and returns to FETCH.
- Assert rst during MEM with dmem_req high -> next cycle dmem_req=0, state=0. Preload instret to all-ones with CNT_W=4 and retire one instruction -> instret=0.
